// File: rtl/bit_unpacker_256bits_pkg.sv
// Shared widths for the 256-bit MSB-first bit unpacker.
// Buffer holds two words; peek window doubles as max consume.
package bit_unpacker_256bits_pkg;

  localparam int UNP_WORD_W = 128;
  localparam int UNP_BUF_W  = 2 * UNP_WORD_W;
  localparam int UNP_PEEK_W = 32;
  localparam int LEN_W      = $clog2(UNP_BUF_W + 1);
  localparam int AMT_W      = $clog2(UNP_PEEK_W + 1);

  typedef logic [LEN_W-1:0] len_t;
  typedef logic [AMT_W-1:0] amt_t;

endpackage

// File: rtl/bit_unpacker_256bits.sv
// MSB-first bit unpacker: 128-bit words in, 0..32-bit consumes out.
// Consume (left shift) is applied before append (right shift by len).
module bit_unpacker_256bits
  import bit_unpacker_256bits_pkg::*;
#(
  parameter int WORD_W = UNP_WORD_W,
  parameter int BUF_W  = UNP_BUF_W,
  parameter int PEEK_W = UNP_PEEK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  input  amt_t              len_in,
  input  logic              consume,
  input  logic              byte_align,
  output logic [PEEK_W-1:0] bits_out,
  output len_t              current_len,
  output logic              underflow,
  output logic              drained
);

  logic [BUF_W-1:0] bit_buf;
  len_t             len_q;
  logic [2:0]       pos_q;
  logic             last_q;
  logic             uf_q;

  logic [BUF_W-1:0] buf_c;
  logic [BUF_W-1:0] buf_n;
  logic [BUF_W-1:0] ext;
  len_t             len_c;
  len_t             len_n;
  logic [2:0]       pos_c;
  logic [2:0]       align_amt;
  amt_t             amt;
  logic             req;
  logic             ok;
  logic             accept;

  // (8 - pos) mod 8 in three bits is just the negation
  assign align_amt = 3'd0 - pos_q;
  assign accept    = data_valid && data_ready;
  assign ext       = {data_in, {(BUF_W-WORD_W){1'b0}}};

  always_comb begin
    amt = '0;
    req = 1'b0;
    unique case (1'b1)
      byte_align: begin
        amt = AMT_W'(align_amt);
        req = 1'b1;
      end
      consume && !byte_align: begin
        amt = len_in;
        req = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ok    = req
         && (amt <= AMT_W'(PEEK_W))
         && (LEN_W'(amt) <= len_q);
    buf_c = bit_buf;
    len_c = len_q;
    pos_c = pos_q;
    if (ok) begin
      buf_c = bit_buf << amt;
      len_c = len_q - LEN_W'(amt);
      pos_c = pos_q + amt[2:0];
    end
    buf_n = buf_c;
    len_n = len_c;
    if (accept) begin
      buf_n = buf_c | (ext >> len_c);
      len_n = len_c + LEN_W'(WORD_W);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_buf <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      bit_buf <= buf_n;
      len_q   <= len_n;
      pos_q   <= pos_c;
      last_q  <= last_q | (accept && data_last);
      uf_q    <= uf_q | (req && !ok);
    end
  end

  assign bits_out    = bit_buf[BUF_W-1 -: PEEK_W];
  assign current_len = len_q;
  assign underflow   = uf_q;
  assign data_ready  = (len_q <= LEN_W'(WORD_W)) && !last_q;
  assign drained     = last_q && (len_q == '0);

endmodule

// File: tb/tb_bit_unpacker_256bits.sv
// Directed bench for bit_unpacker_256bits.
// Expected values are hand-derived from the stream definition.
module tb_bit_unpacker_256bits;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         data_valid;
  logic         data_last;
  logic         data_ready;
  logic [5:0]   len_in;
  logic         consume;
  logic         byte_align;
  logic [31:0]  bits_out;
  logic [8:0]   current_len;
  logic         underflow;
  logic         drained;

  int passed = 0;
  int total  = 0;

  logic [127:0] wa, wb, wx, ww, wy, wz;
  logic [31:0]  e32;

  always #5 clk = ~clk;

  bit_unpacker_256bits dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .len_in     (len_in),
    .consume    (consume),
    .byte_align (byte_align),
    .bits_out   (bits_out),
    .current_len(current_len),
    .underflow  (underflow),
    .drained    (drained)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_valid = 1'b0;
    data_last  = 1'b0;
    consume    = 1'b0;
    byte_align = 1'b0;
    len_in     = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [127:0] w,
                      input logic last);
    data_in    = w;
    data_valid = 1'b1;
    data_last  = last;
    step();
    idle();
  endtask

  task automatic cons(input int n);
    consume = 1'b1;
    len_in  = 6'(n);
    step();
    idle();
  endtask

  initial begin
    wa = 128'h0123456789abcdef_fedcba9876543210;
    wb = 128'hdeadbeefcafef00d_1122334455667788;
    wx = 128'h89abcdef01234567_a5a5a5a55a5a5a5a;
    ww = 128'hc3c3c3c3_12345678_9abcdef0_0f0f0f0f;
    wy = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f3;
    wz = 128'hffff0000ffff0000_ffff0000ffff0000;
    data_in = '0;
    reset   = 1'b1;
    idle();
    #2;
    chk("rst_bits", bits_out, 0);
    chk("rst_len", current_len, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_drained", drained, 0);
    chk("rst_uf", underflow, 0);
    step();
    reset = 1'b0;

    // single word with nibble F at the head
    push({4'hf, 124'b0}, 1'b0);
    chk("acc_len", current_len, 128);
    chk("acc_bits", bits_out, 32'hf0000000);
    chk("acc_ready", data_ready, 1);
    cons(4);
    chk("c4_bits", bits_out, 0);
    chk("c4_len", current_len, 124);
    // byte_align wins over consume of 10
    byte_align = 1'b1;
    consume    = 1'b1;
    len_in     = 6'd10;
    step();
    idle();
    chk("ba_len", current_len, 120);
    byte_align = 1'b1;
    step();
    idle();
    chk("ba_pos0_len", current_len, 120);
    chk("ba_pos0_uf", underflow, 0);
    cons(0);
    chk("c0_len", current_len, 120);
    chk("c0_uf", underflow, 0);
    cons(33);
    chk("c33_uf", underflow, 1);
    chk("c33_len", current_len, 120);

    // back-to-back fill to 256
    do_reset();
    chk("rst2_uf", underflow, 0);
    data_in    = wa;
    data_valid = 1'b1;
    step();
    data_in = wb;
    step();
    idle();
    chk("full_len", current_len, 256);
    chk("full_ready", data_ready, 0);
    e32 = wa[127:96];
    chk("full_bits", bits_out, e32);
    cons(32);
    chk("f32_len", current_len, 224);
    chk("f32_ready", data_ready, 0);
    e32 = wa[95:64];
    chk("f32_bits", bits_out, e32);
    cons(32);
    cons(32);
    cons(32);
    chk("f128_len", current_len, 128);
    chk("f128_ready", data_ready, 1);
    e32 = wb[127:96];
    chk("f128_bits", bits_out, e32);

    // simultaneous consume 20 and accept at len 100
    do_reset();
    push(wx, 1'b0);
    cons(28);
    chk("l100_len", current_len, 100);
    data_in    = ww;
    data_valid = 1'b1;
    consume    = 1'b1;
    len_in     = 6'd20;
    step();
    idle();
    chk("sim_len", current_len, 208);
    e32 = wx[79:48];
    chk("sim_h0", bits_out, e32);
    cons(32);
    e32 = wx[47:16];
    chk("sim_h1", bits_out, e32);
    cons(32);
    e32 = {wx[15:0], ww[127:112]};
    chk("sim_seam", bits_out, e32);
    cons(16);
    e32 = ww[127:96];
    chk("sim_w0", bits_out, e32);
    cons(32);
    e32 = ww[95:64];
    chk("sim_w1", bits_out, e32);
    cons(32);
    e32 = ww[63:32];
    chk("sim_w2", bits_out, e32);
    cons(32);
    e32 = ww[31:0];
    chk("sim_w3", bits_out, e32);
    chk("sim_end_len", current_len, 32);

    // underflow at len 10
    do_reset();
    push(wy, 1'b0);
    cons(32);
    cons(32);
    cons(32);
    cons(22);
    chk("u10_len", current_len, 10);
    e32 = {wy[9:0], 22'b0};
    chk("u10_bits", bits_out, e32);
    cons(11);
    chk("u11_uf", underflow, 1);
    chk("u11_len", current_len, 10);
    chk("u11_bits", bits_out, e32);
    cons(2);
    chk("u2_len", current_len, 8);
    chk("u2_uf", underflow, 1);

    // last word, drain, then refused input
    do_reset();
    push(wz, 1'b1);
    chk("lw_len", current_len, 128);
    chk("lw_ready", data_ready, 0);
    chk("lw_drained", drained, 0);
    cons(32);
    cons(32);
    cons(32);
    cons(32);
    chk("dr_drained", drained, 1);
    chk("dr_ready", data_ready, 0);
    push(wa, 1'b0);
    chk("dr_noacc", current_len, 0);

    // async reset between edges, and no accept while in reset
    do_reset();
    push(wa, 1'b0);
    cons(8);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_bits", bits_out, 0);
    chk("ar_len", current_len, 0);
    chk("ar_ready", data_ready, 1);
    chk("ar_drained", drained, 0);
    data_in    = wb;
    data_valid = 1'b1;
    step();
    idle();
    reset = 1'b0;
    chk("ar_noacc", current_len, 0);
    step();
    chk("ar_post_len", current_len, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
